pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline-stage register with a valid/ready handshake, a two-entry skid buffer, and a synchronous flush that inserts a zero bubble. It is the general successor to the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). Any stage boundary instantiates it with its own lane count, and gets stall and backpressure handling without a combinational ready path between stages.

## Interface
- WIDTH, 32: bits per lane (IR, PC4, PC8, RS, RT, EXT are one lane each).
- LANES, 6: number of lanes carried.
- BUBBLE_ZERO, 1: 1 forces out_data to all-zero (nop) whenever out_valid=0; 0 leaves the last data visible.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  upstream stage offers in_data.
- in_ready  out  1  stage can accept; depends only on internal state.
- in_data  in  LANES*WIDTH  lane k at bits [k*WIDTH +: WIDTH].
- flush  in  1  synchronous bubble insertion (branch/hazard kill).
- out_valid  out  1  out_data holds a live instruction.
- out_ready  in  1  downstream consumes this cycle.
- out_data  out  LANES*WIDTH  main entry.
- occupancy  out  2  entries held (0, 1 or 2).

## Operation
- Accept event: in_valid & in_ready. Consume event: out_valid & out_ready.
- State machine:
  - EMPTY
    - accept -> ONE, main <= in_data.
  - ONE
    - accept & consume -> ONE, main <= in_data.
    - accept only -> TWO, skid <= in_data.
    - consume only -> EMPTY.
    - neither -> ONE, hold.
  - TWO
    - consume -> ONE, main <= skid.
    - otherwise hold.
- Outputs per state:
  - in_ready = (state != TWO).
  - out_valid = (state != EMPTY).
  - occupancy: EMPTY=0, ONE=1, TWO=2.
- Ordering is strictly FIFO: main is always older than skid.
- flush has priority over every event except reset.
  - At the edge: state -> EMPTY, main and skid cleared to 0.
  - A word accepted in the flush cycle is discarded.
  - A word consumed in the flush cycle counts as delivered.
- reset: state EMPTY, main = skid = 0. Same effect as flush, plus it is the power-on state.
- No arithmetic. Data passes bit-exact, and lanes are never reordered.

## Timing
- Reset values:
  - out_valid=0, in_ready=1, occupancy=0.
  - out_data=0 (for either BUBBLE_ZERO value).
- Latency: a word accepted at edge N is on out_data with out_valid=1 after edge N, when the stage was EMPTY (or ONE with simultaneous consume).
- Throughput: one word per cycle sustained.
- Backpressure:
  - out_ready low for k cycles under continuous in_valid absorbs exactly one extra word.
  - in_ready drops the cycle after the skid fills.
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.
- flush asserted in cycle N: out_valid=0 and occupancy=0 from edge N onward. in_ready=1 in cycle N+1.
- reset mid-stream behaves like flush. Handshake outputs during the reset cycle still reflect the pre-reset state.
- Holding in_valid while in_ready=0 is legal. in_data must stay stable until it is accepted.

## Structure
- Shared pipeline package holds:
  - Lane index constants LANE_IR=0, LANE_PC4=1, LANE_PC8=2, LANE_RS=3, LANE_RT=4, LANE_EXT=5.
  - The 2-bit state encoding ST_EMPTY=0, ST_ONE=1, ST_TWO=2.
- One natural sub-module, pipe_lane_mux. It is the per-lane zeroing/selection mux for BUBBLE_ZERO, generated LANES times.
- State, main and skid registers stay in the top module.

## Test plan
- Reset, then idle:
  - occupancy=0, out_valid=0, in_ready=1, out_data=0.
  - in_valid=1 with IR=0x8C010004 -> one edge later out_valid=1 and lane 0 = 0x8C010004.
- Stream 0x1..0x8 with out_ready=1 every cycle -> out_data equals 0x1..0x8 on consecutive cycles, occupancy stays 1.
- Stream 0xA, 0xB, 0xC with out_ready=0 from the cycle after 0xA arrives:
  - occupancy goes 1 -> 2, in_ready=0, 0xC is held.
  - Raising out_ready delivers 0xA, 0xB, 0xC in order.
- flush in the cycle after 0xA and 0xB are both held, with 0xC offered -> occupancy=0, out_data=0, 0xC is never delivered, in_ready=1.
- reset asserted while occupancy=2 -> same cleared state as flush. The next offered word 0x55 appears one edge later.
- LANES=2, WIDTH=16, BUBBLE_ZERO=0: send 0xBEEF_1234 then go idle -> out_valid=0 and out_data keeps 0xBEEF_1234.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: lane positions inside a stage word and the
// two-bit occupancy state encoding used by every stage register.
package pipe_stage_reg_pkg;

  localparam int LANE_IR  = 0;
  localparam int LANE_PC4 = 1;
  localparam int LANE_PC8 = 2;
  localparam int LANE_RS  = 3;
  localparam int LANE_RT  = 4;
  localparam int LANE_EXT = 5;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/pipe_lane_mux.sv
// Per-lane output mux: presents the held lane, or a zero (nop) bubble while
// the stage is empty when BUBBLE_ZERO is set.
module pipe_lane_mux #(
  parameter int WIDTH       = 32,
  parameter int BUBBLE_ZERO = 1
) (
  input  logic             valid,
  input  logic [WIDTH-1:0] lane_in,
  output logic [WIDTH-1:0] lane_out
);

  assign lane_out = ((BUBBLE_ZERO != 0) && !valid) ? '0 : lane_in;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, two-entry skid buffer
// and synchronous flush; in_ready is a pure function of registered state.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int LANES       = 6,
  parameter int BUBBLE_ZERO = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [1:0]             occupancy
);

  logic [1:0]             state_p0;
  logic [LANES*WIDTH-1:0] main_p0;
  logic [LANES*WIDTH-1:0] skid_p0;
  logic                   accept;
  logic                   consume;

  assign in_ready  = (state_p0 != ST_TWO);
  assign out_valid = (state_p0 != ST_EMPTY);
  assign occupancy = state_p0;
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  // Stage p0: main always holds the older word, skid the younger one
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_p0 <= ST_EMPTY;
      main_p0  <= '0;
      skid_p0  <= '0;
    end else begin
      case (state_p0)
        ST_EMPTY: begin
          if (accept) begin
            state_p0 <= ST_ONE;
            main_p0  <= in_data;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_p0 <= in_data;
          end else if (accept) begin
            state_p0 <= ST_TWO;
            skid_p0  <= in_data;
          end else if (consume) begin
            state_p0 <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (consume) begin
            state_p0 <= ST_ONE;
            main_p0  <= skid_p0;
          end
        end
        default: state_p0 <= ST_EMPTY;
      endcase
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    pipe_lane_mux #(
      .WIDTH       (WIDTH),
      .BUBBLE_ZERO (BUBBLE_ZERO)
    ) u_lane_mux (
      .valid    (out_valid),
      .lane_in  (main_p0[k*WIDTH +: WIDTH]),
      .lane_out (out_data[k*WIDTH +: WIDTH])
    );
  end

endmodule
